// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    // Address bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, unregistered read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W  = ptr_width(DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [PTR_W-1:0]      w_wptr_next, w_rptr_next;
    logic [DATA_WIDTH-1:0] r_dout, w_dout_next;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_full, w_empty;
    logic                  w_wr_accept, w_rd_accept;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0])
                  && (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]);

    // A read frees the slot being written when full, so the write may proceed.
    assign w_wr_accept = write_enable && (!w_full || read_enable);
    assign w_rd_accept = read_enable && !w_empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (din),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_wptr_next = r_wptr;
        w_rptr_next = r_rptr;
        w_dout_next = r_dout;
        if (w_wr_accept) begin
            w_wptr_next = r_wptr + PTR_W'(1);
        end
        if (w_rd_accept) begin
            w_rptr_next = r_rptr + PTR_W'(1);
            w_dout_next = w_mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_dout <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            r_dout <= w_dout_next;
        end
    end

    assign dout  = r_dout;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (16 x 8).
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       full;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    function automatic logic [7:0] wrap_val(input int k);
        return 8'((k * 37 + 11) & 8'hFF);
    endfunction

    task automatic test_reset();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            write_enable = 1'($urandom_range(0, 1));
            read_enable  = 1'($urandom_range(0, 1));
            din          = 8'($urandom_range(0, 255));
            step();
        end
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got empty=%b full=%b dout=%h, expected 1 0 00",
                     empty, full, dout);
        end
        idle();
        reset = 1'b1;
        step();
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: got empty=%b full=%b dout=%h, expected 1 0 00",
                     empty, full, dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_enable = 1'b1;
            din          = 8'(8'hFF - i);
            step();
            n_tests++;
            if (empty !== 1'b0 || full !== (i == 15)) begin
                n_fail++;
                $display("FAIL fill[%0d]: got empty=%b full=%b, expected 0 %b",
                         i, empty, full, (i == 15));
            end
        end
        din = 8'hAA;
        step();
        n_tests++;
        if (full !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL fill_overflow: got full=%b dout=%h, expected 1 00", full, dout);
        end
        idle();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            read_enable = 1'b1;
            step();
            n_tests++;
            if (dout !== 8'(8'hFF - i) || empty !== (i == 15) || full !== 1'b0) begin
                n_fail++;
                $display("FAIL drain[%0d]: got dout=%h empty=%b full=%b, expected %h %b 0",
                         i, dout, empty, full, 8'(8'hFF - i), (i == 15));
            end
        end
        step();
        n_tests++;
        if (dout !== 8'hF0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_underflow: got dout=%h empty=%b, expected f0 1", dout, empty);
        end
        idle();
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) begin
            write_enable = 1'b1;
            din          = 8'(8'hFF - i);
            step();
        end
        n_tests++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL simfull_prefill: got full=%b, expected 1", full);
        end
        read_enable = 1'b1;
        din         = 8'h55;
        step();
        n_tests++;
        if (dout !== 8'hFF || full !== 1'b1) begin
            n_fail++;
            $display("FAIL simfull_rw: got dout=%h full=%b, expected ff 1", dout, full);
        end
        write_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            n_tests++;
            if (dout !== ((i == 15) ? 8'h55 : 8'(8'hFE - i))) begin
                n_fail++;
                $display("FAIL simfull_drain[%0d]: got dout=%h, expected %h",
                         i, dout, ((i == 15) ? 8'h55 : 8'(8'hFE - i)));
            end
        end
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL simfull_empty: got empty=%b, expected 1", empty);
        end
        idle();
    endtask

    task automatic test_simul_empty();
        write_enable = 1'b1;
        read_enable  = 1'b1;
        din          = 8'h33;
        step();
        n_tests++;
        if (dout !== 8'h55 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL simempty_rw: got dout=%h empty=%b, expected 55 0", dout, empty);
        end
        write_enable = 1'b0;
        step();
        n_tests++;
        if (dout !== 8'h33 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL simempty_read: got dout=%h empty=%b, expected 33 1", dout, empty);
        end
        idle();
    endtask

    task automatic test_wrap();
        write_enable = 1'b1;
        din          = wrap_val(0);
        step();
        read_enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            din = wrap_val(k);
            step();
            n_tests++;
            if (dout !== wrap_val(k - 1) || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got dout=%h empty=%b, expected %h 0",
                         k, dout, empty, wrap_val(k - 1));
            end
        end
        write_enable = 1'b0;
        step();
        n_tests++;
        if (dout !== wrap_val(40) || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_last: got dout=%h empty=%b, expected %h 1",
                     dout, empty, wrap_val(40));
        end
        idle();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            write_enable = 1'b1;
            din          = 8'(8'h10 + i);
            step();
        end
        idle();
        n_tests++;
        if (empty !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pre: got empty=%b, expected 0", empty);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_async: got empty=%b full=%b dout=%h, expected 1 0 00",
                     empty, full, dout);
        end
        step();
        reset       = 1'b1;
        read_enable = 1'b1;
        step();
        n_tests++;
        if (empty !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_after: got empty=%b dout=%h, expected 1 00", empty, dout);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_simul_empty();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
